// File: rtl/enc_demux_reg.sv
// Purpose: captures a one-hot-low request, encodes it to an index, and routes the captured data to one of four destination registers.
// Latency: a request sampled at edge k gives idx/err/idx_valid and the updated out_* after edge k+1.
// Backpressure: results hold in PRESENT until out_ready is sampled high; a held request is never captured twice.
module enc_demux_reg (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [3:0] req_n,
    input  logic [1:0] din,
    input  logic       out_ready,
    output logic [1:0] idx,
    output logic       idx_valid,
    output logic       err,
    output logic [1:0] out_a,
    output logic [1:0] out_b,
    output logic [1:0] out_c,
    output logic [1:0] out_d,
    output logic       busy,
    output logic [3:0] wr_count
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ENC     = 2'd1,
        S_PRESENT = 2'd2,
        S_RELEASE = 2'd3
    } state_t;

    // Pattern meaning "no request asserted" on the active-low request lines.
    localparam logic [3:0] REQ_NONE = 4'b1111;

    state_t     state_q, state_d;
    logic [3:0] req_q, req_d;
    logic [1:0] din_q, din_d;
    logic [1:0] idx_q, idx_d;
    logic       err_q, err_d;
    logic       idx_valid_q, idx_valid_d;
    logic [1:0] out_a_q, out_a_d;
    logic [1:0] out_b_q, out_b_d;
    logic [1:0] out_c_q, out_c_d;
    logic [1:0] out_d_q, out_d_d;
    logic [3:0] wr_count_q, wr_count_d;

    logic [1:0] enc_idx;
    logic       enc_err;
    logic [2:0] low_cnt;

    // Priority encoder on the captured request: lowest-numbered low bit wins, err flags multiple low bits.
    always_comb begin
        enc_idx = 2'd0;
        low_cnt = 3'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!req_q[i]) begin
                enc_idx = i[1:0];
            end
        end
        for (int i = 0; i < 4; i++) begin
            low_cnt = low_cnt + {2'b00, ~req_q[i]};
        end
        enc_err = (low_cnt > 3'd1);
    end

    // Next-state and next-output logic; every register holds unless its state explicitly updates it.
    always_comb begin
        state_d     = state_q;
        req_d       = req_q;
        din_d       = din_q;
        idx_d       = idx_q;
        err_d       = err_q;
        idx_valid_d = idx_valid_q;
        out_a_d     = out_a_q;
        out_b_d     = out_b_q;
        out_c_d     = out_c_q;
        out_d_d     = out_d_q;
        wr_count_d  = wr_count_q;

        case (state_q)
            S_IDLE: begin
                // With en low the request lines are not looked at at all.
                if (en && (req_n != REQ_NONE)) begin
                    req_d   = req_n;
                    din_d   = din;
                    state_d = S_ENC;
                end
            end
            S_ENC: begin
                // Only the values registered in IDLE are used here; live inputs are ignored.
                idx_d       = enc_idx;
                err_d       = enc_err;
                idx_valid_d = 1'b1;
                case (enc_idx)
                    2'd0:    out_a_d = din_q;
                    2'd1:    out_b_d = din_q;
                    2'd2:    out_c_d = din_q;
                    default: out_d_d = din_q;
                endcase
                state_d = S_PRESENT;
            end
            S_PRESENT: begin
                // Results stay frozen until the consumer takes them.
                if (out_ready) begin
                    idx_valid_d = 1'b0;
                    wr_count_d  = wr_count_q + 4'd1;
                    state_d     = S_RELEASE;
                end
            end
            S_RELEASE: begin
                // Wait for the requester to let go so a held request is not captured twice.
                if (req_n == REQ_NONE) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers; synchronous reset overrides every transition.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            req_q       <= REQ_NONE;
            din_q       <= 2'd0;
            idx_q       <= 2'd0;
            err_q       <= 1'b0;
            idx_valid_q <= 1'b0;
            out_a_q     <= 2'd0;
            out_b_q     <= 2'd0;
            out_c_q     <= 2'd0;
            out_d_q     <= 2'd0;
            wr_count_q  <= 4'd0;
        end else begin
            state_q     <= state_d;
            req_q       <= req_d;
            din_q       <= din_d;
            idx_q       <= idx_d;
            err_q       <= err_d;
            idx_valid_q <= idx_valid_d;
            out_a_q     <= out_a_d;
            out_b_q     <= out_b_d;
            out_c_q     <= out_c_d;
            out_d_q     <= out_d_d;
            wr_count_q  <= wr_count_d;
        end
    end

    assign idx       = idx_q;
    assign err       = err_q;
    assign idx_valid = idx_valid_q;
    assign out_a     = out_a_q;
    assign out_b     = out_b_q;
    assign out_c     = out_c_q;
    assign out_d     = out_d_q;
    assign wr_count  = wr_count_q;
    assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_enc_demux_reg.sv
// Testbench for enc_demux_reg: table-driven transactions plus directed reset and idle-enable sequences.
// Inputs change #1 after the rising edge and outputs are sampled there too.
// The consumer handshake is driven per vector (immediate or stalled accept).
module tb_enc_demux_reg;

    logic       clk;
    logic       rst;
    logic       en;
    logic [3:0] req_n;
    logic [1:0] din;
    logic       out_ready;
    logic [1:0] idx;
    logic       idx_valid;
    logic       err;
    logic [1:0] out_a;
    logic [1:0] out_b;
    logic [1:0] out_c;
    logic [1:0] out_d;
    logic       busy;
    logic [3:0] wr_count;

    int n_tests;
    int n_fail;

    logic [1:0] m_out [4];
    logic [3:0] m_wr;

    typedef struct {
        logic [3:0] req_n;
        logic [1:0] din;
        logic [1:0] exp_idx;
        logic       exp_err;
        int         stall;
        int         hold;
    } vec_t;

    vec_t vecs [8];

    enc_demux_reg dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .req_n     (req_n),
        .din       (din),
        .out_ready (out_ready),
        .idx       (idx),
        .idx_valid (idx_valid),
        .err       (err),
        .out_a     (out_a),
        .out_b     (out_b),
        .out_c     (out_c),
        .out_d     (out_d),
        .busy      (busy),
        .wr_count  (wr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_outs(input string tag);
        chk({tag, "_out_a"}, {6'd0, out_a}, {6'd0, m_out[0]});
        chk({tag, "_out_b"}, {6'd0, out_b}, {6'd0, m_out[1]});
        chk({tag, "_out_c"}, {6'd0, out_c}, {6'd0, m_out[2]});
        chk({tag, "_out_d"}, {6'd0, out_d}, {6'd0, m_out[3]});
        chk({tag, "_wr"}, {4'd0, wr_count}, {4'd0, m_wr});
    endtask

    task automatic chk_present(input string tag, input vec_t v);
        chk({tag, "_idx"}, {6'd0, idx}, {6'd0, v.exp_idx});
        chk({tag, "_err"}, {7'd0, err}, {7'd0, v.exp_err});
        chk({tag, "_vld"}, {7'd0, idx_valid}, 8'd1);
        chk({tag, "_busy"}, {7'd0, busy}, 8'd1);
        chk_outs(tag);
    endtask

    // One full transfer from IDLE back to IDLE.
    task automatic run_txn(input vec_t v);
        en        = 1'b1;
        req_n     = v.req_n;
        din       = v.din;
        out_ready = (v.stall == 0);
        step();
        chk("cap_busy", {7'd0, busy}, 8'd1);
        chk("cap_vld", {7'd0, idx_valid}, 8'd0);
        // Scramble live inputs during ENC; only captured values may be used.
        en    = 1'b0;
        din   = ~v.din;
        req_n = 4'($urandom);
        step();
        m_out[v.exp_idx] = v.din;
        chk_present("enc", v);
        for (int s = 0; s < v.stall; s++) begin
            en        = 1'($urandom);
            din       = 2'($urandom);
            req_n     = 4'($urandom);
            out_ready = 1'b0;
            step();
            chk_present("stall", v);
        end
        out_ready = 1'b1;
        step();
        m_wr = m_wr + 4'd1;
        chk("acc_vld", {7'd0, idx_valid}, 8'd0);
        chk("acc_idx_hold", {6'd0, idx}, {6'd0, v.exp_idx});
        chk("acc_err_hold", {7'd0, err}, {7'd0, v.exp_err});
        chk("acc_busy", {7'd0, busy}, 8'd1);
        chk_outs("acc");
        out_ready = 1'b0;
        en        = 1'b1;
        req_n     = v.req_n;
        din       = 2'($urandom);
        for (int h = 0; h < v.hold; h++) begin
            step();
            chk("hold_busy", {7'd0, busy}, 8'd1);
            chk("hold_vld", {7'd0, idx_valid}, 8'd0);
            chk("hold_wr", {4'd0, wr_count}, {4'd0, m_wr});
        end
        req_n = 4'b1111;
        step();
        chk("rel_busy", {7'd0, busy}, 8'd0);
        chk_outs("rel");
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        m_wr    = 4'd0;
        for (int i = 0; i < 4; i++) m_out[i] = 2'd0;

        vecs[0] = '{4'b1011, 2'b10, 2'd2, 1'b0, 0, 0};
        vecs[1] = '{4'b0101, 2'b11, 2'd1, 1'b1, 0, 5};
        vecs[2] = '{4'b1110, 2'b01, 2'd0, 1'b0, 10, 1};
        vecs[3] = '{4'b0111, 2'b11, 2'd3, 1'b0, 2, 0};
        vecs[4] = '{4'b0000, 2'b10, 2'd0, 1'b1, 1, 2};
        vecs[5] = '{4'b1101, 2'b01, 2'd1, 1'b0, 0, 1};
        vecs[6] = '{4'b1100, 2'b11, 2'd0, 1'b1, 3, 0};
        vecs[7] = '{4'b0110, 2'b01, 2'd0, 1'b1, 0, 3};

        rst       = 1'b1;
        en        = 1'b0;
        req_n     = 4'b1111;
        din       = 2'b00;
        out_ready = 1'b0;
        step();
        step();
        rst = 1'b0;
        chk("rst_idx", {6'd0, idx}, 8'd0);
        chk("rst_err", {7'd0, err}, 8'd0);
        chk("rst_vld", {7'd0, idx_valid}, 8'd0);
        chk("rst_busy", {7'd0, busy}, 8'd0);
        chk_outs("rst");

        // Two passes through the table give 16 transfers, so wr_count wraps 15 -> 0 on the last one.
        for (int pass = 0; pass < 2; pass++) begin
            for (int i = 0; i < 8; i++) begin
                run_txn(vecs[i]);
            end
        end
        chk("wrap_wr", {4'd0, wr_count}, 8'd0);

        // en low: request lines must be ignored.
        en    = 1'b0;
        req_n = 4'b1110;
        din   = 2'b11;
        for (int c = 0; c < 3; c++) begin
            step();
            chk("en0_busy", {7'd0, busy}, 8'd0);
            chk("en0_vld", {7'd0, idx_valid}, 8'd0);
            chk_outs("en0");
        end

        // Reset in PRESENT with the request still held low.
        en        = 1'b1;
        req_n     = 4'b0111;
        din       = 2'b01;
        out_ready = 1'b0;
        step();
        step();
        m_out[3] = 2'b01;
        chk("pre_rst_vld", {7'd0, idx_valid}, 8'd1);
        chk_outs("pre_rst");
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) m_out[i] = 2'd0;
        m_wr = 4'd0;
        chk("mid_rst_idx", {6'd0, idx}, 8'd0);
        chk("mid_rst_err", {7'd0, err}, 8'd0);
        chk("mid_rst_vld", {7'd0, idx_valid}, 8'd0);
        chk("mid_rst_busy", {7'd0, busy}, 8'd0);
        chk_outs("mid_rst");
        din = 2'b10;
        step();
        chk("recap_busy", {7'd0, busy}, 8'd1);
        step();
        m_out[3] = 2'b10;
        chk("recap_idx", {6'd0, idx}, 8'd3);
        chk("recap_vld", {7'd0, idx_valid}, 8'd1);
        chk_outs("recap");
        out_ready = 1'b1;
        step();
        m_wr = 4'd1;
        chk("recap_acc_vld", {7'd0, idx_valid}, 8'd0);
        chk_outs("recap_acc");
        out_ready = 1'b0;
        req_n     = 4'b1111;
        step();
        chk("final_busy", {7'd0, busy}, 8'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
